fsmc_sdram_bridge: RTL and testbench
====================================

# fsmc_sdram_bridge

Register-mapped bridge between the STM32 FSMC bus slave (`clocked_bus_slave`) and `sdram_controller`, replacing the single-shot ADR/DATA register logic in the top level. It adds the following:
- a parametrised posted-write queue;
- a one-word read prefetch;
- address auto-increment;
- status and error flags.

The STM32 can stream SDRAM words through one DATA register without polling busy between every word.

## Interface
Parameters:
- `DW`, 16, FSMC and SDRAM data width.
- `AW`, 8, FSMC register address width.
- `SAW`, 27, SDRAM word address width.
- `QDEPTH`, 8, write-queue depth in entries; must be a power of 2, at least 2.

Ports:
- `clk` input 1: single clock (PLL clock); all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fsmc_r_adr` input AW: read register address.
- `fsmc_do_read` input 1: one-cycle read strobe.
- `fsmc_r_data` output DW: read data, combinational from `fsmc_r_adr`.
- `fsmc_w_adr` input AW: write register address.
- `fsmc_do_write` input 1: one-cycle write strobe.
- `fsmc_w_data` input DW: write data.
- `sdram_init_done` input 1: controller initialisation complete.
- `sdram_busy` input 1: controller busy.
- `sdram_data_valid` input 1: read data valid.
- `sdram_write_done` input 1: write complete.
- `sdram_data_out` input DW: read data from controller.
- `sdram_adv` output 1: request strobe.
- `sdram_rwn` output 1: request direction; 1 = write, 0 = read.
- `sdram_i_addr` output SAW: request address.
- `sdram_data_in` output DW: write data.

## Operation
Register map (byte offsets):

| Offset | Name | Write | Read |
|---|---|---|---|
| 0x00 | ADR_LOW | `adr[14:0]=w[15:1]`; if `w[0]=0`, requests a prefetch at the new `adr` | `{adr[14:0], busy}` |
| 0x02 | ADR_HIGH | `adr[SAW-1:15]=w[11:0]`; no trigger | `adr[SAW-1:15]`, zero-extended |
| 0x04 | DATA | push `{adr, w}` to the queue; if `autoinc`, `adr+=1` | `pf_data` (see below) |
| 0x06 | STATUS | — | see below |
| 0x08 | CTRL | `w[0]` sets `autoinc`; `w[1]=1` clears `ovf` and `unf` | — |

- `busy` = queue not empty OR state ≠ IDLE OR prefetch requested.
- DATA read (`fsmc_do_read` at 0x04):
  - `pf_valid=1`: clear `pf_valid`; if `autoinc`, `adr+=1` and request a prefetch at the new `adr`.
  - `pf_valid=0`: set sticky `unf`; `adr` unchanged.
- STATUS read value: `{count[7:0], 3'b0, unf, ovf, pf_valid, full, sdram_init_done}`.
- Unmapped addresses read as 0; writes to them are ignored.

Address and queue rules:
- `adr` wraps from `2^SAW-1` to 0.
- Queue full on a DATA write: the word is dropped, `ovf` is set, and `adr` still increments.
- Any DATA write or ADR_LOW/ADR_HIGH write clears `pf_valid` and cancels any pending prefetch request.
- Coherency: a pending prefetch is issued only when the queue is empty. Writes therefore always reach SDRAM before a later read.

State machine:
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
- Define `idle_ok = sdram_init_done && !sdram_busy`.
- IDLE → WR_ISSUE when the queue is not empty and `idle_ok`. This has priority over reads.
- IDLE → RD_ISSUE when a prefetch is requested, the queue is empty, and `idle_ok`.
- WR_ISSUE → WR_WAIT after one cycle. The queue head is popped on entry to WR_WAIT.
- WR_WAIT → IDLE on `sdram_write_done`.
- RD_ISSUE → RD_WAIT after one cycle.
- RD_WAIT → IDLE on `sdram_data_valid`: capture `pf_data=sdram_data_out` and set `pf_valid=1`, unless the read was cancelled while in flight. A cancelled read discards its data.

## Timing
- Reset state:
  - Outputs: `sdram_adv=0`, `sdram_rwn=0`, `sdram_i_addr=0`, `sdram_data_in=0`.
  - Internal: state IDLE, queue empty, `adr=0`, `autoinc=1`, `pf_valid=0`, `pf_data=0`, `ovf=0`, `unf=0`.
  - Reset asserted mid-transaction abandons it immediately. The controller is reset by the same source.
- `sdram_adv` is registered and high for exactly one cycle, in WR_ISSUE or RD_ISSUE. `sdram_rwn`, `sdram_i_addr` and `sdram_data_in` are stable from that cycle until the state returns to IDLE.
- Register writes take effect one cycle after `fsmc_do_write`. The earliest `sdram_adv` is 2 cycles after the DATA write strobe.
- Simultaneous push and pop in the same cycle: `count` is unchanged, and the entry is accepted even when the queue is full.
- Simultaneous DATA read pop and `sdram_data_valid` of a new prefetch cannot occur: a prefetch is only requested after the pop.
- `fsmc_r_data` is combinational and has no latency.

## Structure
- Package `fsmc_sdram_pkg`: register offsets `REG_ADR_LOW`/`REG_ADR_HIGH`/`REG_DATA`/`REG_STATUS`/`REG_CTRL`, the state enum, and STATUS bit indices.
- Sub-module `bridge_wr_fifo`:
  - Synchronous FIFO, width `SAW+DW`, depth `QDEPTH`.
  - Ports: `push`, `pop`, `full`, `empty`, `count`.
  - First-word fall-through head.

## Test plan
- Write ADR_HIGH=0x001 then ADR_LOW=0x0001 (`w[0]=1`, no prefetch), then 3 DATA writes 0xA0, 0xA1, 0xA2 → controller sees 3 write requests (`sdram_rwn=1`) at addresses 0x8000, 0x8001, 0x8002, each with one `sdram_adv` pulse.
- Hold `sdram_busy=1` and make 9 DATA writes with `QDEPTH=8` → `full=1`, `ovf=1`, and the 9th word never issued; CTRL write 0x2 clears `ovf`.
- ADR_LOW write 0x0010 (`w[0]=0`), model returns 0x1234 → `pf_valid=1`, DATA reads 0x1234; that read auto-issues a read at 0x0009.
- DATA read while `pf_valid=0` → `unf=1`, `adr` unchanged, no SDRAM request.
- Queue writes then request a prefetch of the same address → read is issued only after the last `sdram_write_done` and returns the written value.
- `adr=2^27-1`, DATA write → next `adr=0`; assert `rst` during WR_WAIT → every output is 0 on the next cycle.

Source files
------------

// File: rtl/fsmc_sdram_pkg.sv
// fsmc_sdram_bridge shared definitions.
// Register offsets, FSM states and STATUS bit positions.
package fsmc_sdram_pkg;

  localparam int unsigned REG_ADR_LOW  = 32'h00;
  localparam int unsigned REG_ADR_HIGH = 32'h02;
  localparam int unsigned REG_DATA     = 32'h04;
  localparam int unsigned REG_STATUS   = 32'h06;
  localparam int unsigned REG_CTRL     = 32'h08;

  localparam int ST_INIT = 0;
  localparam int ST_FULL = 1;
  localparam int ST_PFV  = 2;
  localparam int ST_OVF  = 3;
  localparam int ST_UNF  = 4;
  localparam int ST_CNT  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT
  } state_e;

endpackage

// File: rtl/fsmc_sdram_bridge_fifo.sv
// Posted-write queue for fsmc_sdram_bridge.
// First-word fall-through; a push is taken when full if a pop coincides.
module bridge_wr_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push)
                     - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fsmc_sdram_bridge.sv
// FSMC register bridge to sdram_controller: posted writes,
// one-word read prefetch, address auto-increment, status flags.
module fsmc_sdram_bridge
  import fsmc_sdram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int SAW    = 27,
  parameter int QDEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  fsmc_r_adr,
  input  logic           fsmc_do_read,
  output logic [DW-1:0]  fsmc_r_data,
  input  logic [AW-1:0]  fsmc_w_adr,
  input  logic           fsmc_do_write,
  input  logic [DW-1:0]  fsmc_w_data,
  input  logic           sdram_init_done,
  input  logic           sdram_busy,
  input  logic           sdram_data_valid,
  input  logic           sdram_write_done,
  input  logic [DW-1:0]  sdram_data_out,
  output logic           sdram_adv,
  output logic           sdram_rwn,
  output logic [SAW-1:0] sdram_i_addr,
  output logic [DW-1:0]  sdram_data_in
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int HW = SAW - 15;
  localparam int QW = SAW + DW;

  state_e         state_q, state_d;
  logic           adv_q, adv_d;
  logic           rwn_q, rwn_d;
  logic [SAW-1:0] addr_q, addr_d;
  logic [DW-1:0]  din_q, din_d;

  logic [SAW-1:0] adr_q, adr_d;
  logic           auto_q, auto_d;
  logic           pfv_q, pfv_d;
  logic [DW-1:0]  pfd_q, pfd_d;
  logic           pfr_q, pfr_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           cxl_q, cxl_d;

  logic [QW-1:0]  q_head;
  logic           q_full, q_empty, q_pop;
  logic [CW-1:0]  q_count;

  logic wr_lo, wr_hi, wr_data, wr_ctrl, rd_data;
  logic cancel_ev, idle_ok, rd_go, busy;

  assign wr_lo   = fsmc_do_write && fsmc_w_adr == AW'(REG_ADR_LOW);
  assign wr_hi   = fsmc_do_write && fsmc_w_adr == AW'(REG_ADR_HIGH);
  assign wr_data = fsmc_do_write && fsmc_w_adr == AW'(REG_DATA);
  assign wr_ctrl = fsmc_do_write && fsmc_w_adr == AW'(REG_CTRL);
  assign rd_data = fsmc_do_read  && fsmc_r_adr == AW'(REG_DATA);

  assign cancel_ev = wr_lo || wr_hi || wr_data;
  assign idle_ok   = sdram_init_done && !sdram_busy;
  assign rd_go     = (state_q == S_IDLE) && (state_d == S_RD_ISSUE);
  assign busy      = !q_empty || (state_q != S_IDLE) || pfr_q;

  bridge_wr_fifo #(
    .W     (QW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .wdata ({adr_q, fsmc_w_data}),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      adv_q   <= 1'b0;
      rwn_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      adv_q   <= adv_d;
      rwn_q   <= rwn_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // Queued writes always win so reads observe earlier posted data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty && idle_ok)
          state_d = S_WR_ISSUE;
        else if (pfr_q && q_empty && idle_ok)
          state_d = S_RD_ISSUE;
      end
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_WR_WAIT:  if (sdram_write_done) state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  if (sdram_data_valid) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adv_d  = (state_d == S_WR_ISSUE) || (state_d == S_RD_ISSUE);
    rwn_d  = rwn_q;
    addr_d = addr_q;
    din_d  = din_q;
    q_pop  = (state_q == S_WR_ISSUE);
    if (state_q == S_IDLE && state_d == S_WR_ISSUE) begin
      rwn_d  = 1'b1;
      addr_d = q_head[QW-1:DW];
      din_d  = q_head[DW-1:0];
    end else if (rd_go) begin
      rwn_d  = 1'b0;
      addr_d = adr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q  <= '0;
      auto_q <= 1'b1;
      pfv_q  <= 1'b0;
      pfd_q  <= '0;
      pfr_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      cxl_q  <= 1'b0;
    end else begin
      adr_q  <= adr_d;
      auto_q <= auto_d;
      pfv_q  <= pfv_d;
      pfd_q  <= pfd_d;
      pfr_q  <= pfr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      cxl_q  <= cxl_d;
    end
  end

  always_comb begin
    adr_d  = adr_q;
    auto_d = auto_q;
    pfv_d  = pfv_q;
    pfd_d  = pfd_q;
    pfr_d  = pfr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (state_q == S_RD_WAIT && sdram_data_valid
        && !cxl_q && !cancel_ev) begin
      pfv_d = 1'b1;
      pfd_d = sdram_data_out;
    end
    if (rd_go) pfr_d = 1'b0;
    if (rd_data) begin
      if (pfv_q) begin
        pfv_d = 1'b0;
        if (auto_q) begin
          adr_d = adr_q + SAW'(1);
          pfr_d = 1'b1;
        end
      end else begin
        unf_d = 1'b1;
      end
    end
    if (wr_lo) begin
      adr_d[14:0] = fsmc_w_data[15:1];
      pfr_d       = !fsmc_w_data[0];
      pfv_d       = 1'b0;
    end
    if (wr_hi) begin
      adr_d[SAW-1:15] = fsmc_w_data[HW-1:0];
      pfr_d           = 1'b0;
      pfv_d           = 1'b0;
    end
    if (wr_data) begin
      if (auto_q) adr_d = adr_q + SAW'(1);
      pfr_d = 1'b0;
      pfv_d = 1'b0;
      if (q_full && !q_pop) ovf_d = 1'b1;
    end
    if (wr_ctrl) begin
      auto_d = fsmc_w_data[0];
      if (fsmc_w_data[1]) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
    end
  end

  // An in-flight read whose address was overridden must not land.
  always_comb begin
    cxl_d = 1'b0;
    if (state_d == S_RD_ISSUE || state_d == S_RD_WAIT)
      cxl_d = cxl_q || cancel_ev;
  end

  always_comb begin
    fsmc_r_data = '0;
    case (fsmc_r_adr)
      AW'(REG_ADR_LOW):  fsmc_r_data = DW'({adr_q[14:0], busy});
      AW'(REG_ADR_HIGH): fsmc_r_data = DW'(adr_q[SAW-1:15]);
      AW'(REG_DATA):     fsmc_r_data = pfd_q;
      AW'(REG_STATUS): begin
        fsmc_r_data[ST_INIT]     = sdram_init_done;
        fsmc_r_data[ST_FULL]     = q_full;
        fsmc_r_data[ST_PFV]      = pfv_q;
        fsmc_r_data[ST_OVF]      = ovf_q;
        fsmc_r_data[ST_UNF]      = unf_q;
        fsmc_r_data[ST_CNT +: 8] = 8'(q_count);
      end
      default: fsmc_r_data = '0;
    endcase
  end

  assign sdram_adv     = adv_q;
  assign sdram_rwn     = rwn_q;
  assign sdram_i_addr  = addr_q;
  assign sdram_data_in = din_q;

endmodule

// File: tb/tb_fsmc_sdram_bridge.sv
// Randomized bench for fsmc_sdram_bridge against a
// transaction-level model with a simple sdram_controller stand-in.
module tb_fsmc_sdram_bridge;
  import fsmc_sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fsmc_r_adr, fsmc_w_adr;
  logic        fsmc_do_read, fsmc_do_write;
  logic [15:0] fsmc_r_data, fsmc_w_data;
  logic        sdram_init_done, sdram_busy;
  logic        sdram_data_valid, sdram_write_done;
  logic [15:0] sdram_data_out;
  logic        sdram_adv, sdram_rwn;
  logic [26:0] sdram_i_addr;
  logic [15:0] sdram_data_in;

  always #5 clk = ~clk;

  fsmc_sdram_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .fsmc_r_adr       (fsmc_r_adr),
    .fsmc_do_read     (fsmc_do_read),
    .fsmc_r_data      (fsmc_r_data),
    .fsmc_w_adr       (fsmc_w_adr),
    .fsmc_do_write    (fsmc_do_write),
    .fsmc_w_data      (fsmc_w_data),
    .sdram_init_done  (sdram_init_done),
    .sdram_busy       (sdram_busy),
    .sdram_data_valid (sdram_data_valid),
    .sdram_write_done (sdram_write_done),
    .sdram_data_out   (sdram_data_out),
    .sdram_adv        (sdram_adv),
    .sdram_rwn        (sdram_rwn),
    .sdram_i_addr     (sdram_i_addr),
    .sdram_data_in    (sdram_data_in)
  );

  int n_chk = 0;
  int n_bad = 0;
  int proto_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [26:0] a);
    return a[15:0] ^ 16'h5A5A ^ {5'h0, a[26:16]};
  endfunction

  // sdram_controller stand-in
  logic [15:0] cmem [logic [26:0]];
  logic [43:0] got_q [$];
  logic        c_busy, c_done, c_valid, c_rwn, adv_prev;
  logic [26:0] c_addr;
  logic [15:0] c_din, c_dout;
  int          c_cnt;
  logic        hold_busy;
  int          fixed_lat;

  assign sdram_busy       = c_busy | hold_busy;
  assign sdram_write_done = c_done;
  assign sdram_data_valid = c_valid;
  assign sdram_data_out   = c_dout;

  always @(posedge clk) begin
    if (rst) begin
      c_busy <= 0; c_done <= 0; c_valid <= 0;
      c_cnt <= 0; adv_prev <= 0;
    end else begin
      c_done <= 0; c_valid <= 0;
      adv_prev <= sdram_adv;
      if (sdram_adv) begin
        if (c_busy || adv_prev) proto_err++;
        got_q.push_back({sdram_rwn, sdram_i_addr,
                         sdram_rwn ? sdram_data_in : 16'h0});
        c_busy <= 1;
        c_cnt  <= fixed_lat > 0 ? fixed_lat
                                : int'($urandom_range(0, 3));
        c_rwn  <= sdram_rwn;
        c_addr <= sdram_i_addr;
        c_din  <= sdram_data_in;
      end else if (c_busy) begin
        if (c_cnt == 0) begin
          c_busy <= 0;
          if (c_rwn) begin
            cmem[c_addr] = c_din;
            c_done <= 1;
          end else begin
            c_dout  <= cmem.exists(c_addr) ? cmem[c_addr]
                                           : dflt(c_addr);
            c_valid <= 1;
          end
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
    end
  end

  // transaction-level model of the bridge
  logic [15:0] rmem [logic [26:0]];
  logic [43:0] exp_q [$];
  logic [26:0] m_adr;
  logic        m_auto, m_pfv, m_ovf, m_unf;
  logic [15:0] m_pfd;

  function automatic logic [15:0] rread(input logic [26:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  task automatic m_reset();
    m_adr = '0; m_auto = 1; m_pfv = 0;
    m_pfd = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic m_fetch();
    exp_q.push_back({1'b0, m_adr, 16'h0});
    m_pfv = 1;
    m_pfd = rread(m_adr);
  endtask

  task automatic m_wr(input logic [15:0] w, input bit drop);
    if (drop) m_ovf = 1;
    else begin
      exp_q.push_back({1'b1, m_adr, w});
      rmem[m_adr] = w;
    end
    if (m_auto) m_adr = m_adr + 27'd1;
    m_pfv = 0;
  endtask

  task automatic m_lo(input logic [15:0] w);
    m_adr = {m_adr[26:15], w[15:1]};
    m_pfv = 0;
    if (!w[0]) m_fetch();
  endtask

  task automatic m_hi(input logic [15:0] w);
    m_adr = {w[11:0], m_adr[14:0]};
    m_pfv = 0;
  endtask

  task automatic m_rd();
    if (m_pfv) begin
      m_pfv = 0;
      if (m_auto) begin
        m_adr = m_adr + 27'd1;
        m_fetch();
      end
    end else m_unf = 1;
  endtask

  task automatic m_ctrl(input logic [15:0] w);
    m_auto = w[0];
    if (w[1]) begin m_ovf = 0; m_unf = 0; end
  endtask

  function automatic logic [15:0] exp_st(input int cnt, input bit full);
    return {8'(cnt), 3'b0, m_unf, m_ovf, m_pfv, full, sdram_init_done};
  endfunction

  // bus access, entered and left on a falling edge
  task automatic wreg(input int unsigned a, input logic [15:0] d);
    fsmc_w_adr = 8'(a); fsmc_w_data = d; fsmc_do_write = 1;
    @(negedge clk);
    fsmc_do_write = 0;
  endtask

  task automatic rreg(input int unsigned a, input bit stb,
                      output logic [15:0] d);
    fsmc_r_adr = 8'(a);
    #1 d = fsmc_r_data;
    fsmc_do_read = stb;
    @(negedge clk);
    fsmc_do_read = 0;
  endtask

  task automatic wait_idle(input string tag);
    logic [15:0] v;
    int n = 0;
    do begin rreg(REG_ADR_LOW, 0, v); n++; end
    while (v[0] && n < 400);
    if (v[0]) chk({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nreq"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_req"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic verify(input string tag);
    logic [15:0] v;
    cmp_log(tag);
    rreg(REG_STATUS, 0, v);   chk({tag, "_st"}, v, exp_st(0, 0));
    rreg(REG_DATA, 0, v);     chk({tag, "_pfd"}, v, m_pfd);
    rreg(REG_ADR_LOW, 0, v);  chk({tag, "_alo"}, v, {m_adr[14:0], 1'b0});
    rreg(REG_ADR_HIGH, 0, v); chk({tag, "_ahi"}, v, 16'(m_adr[26:15]));
  endtask

  initial begin
    logic [15:0] v, d;
    int n0;
    rst = 1; fsmc_r_adr = 0; fsmc_w_adr = 0; fsmc_w_data = 0;
    fsmc_do_read = 0; fsmc_do_write = 0; sdram_init_done = 0;
    hold_busy = 0; fixed_lat = 0;
    m_reset();
    cmem[27'd8] = 16'h1234;
    rmem[27'd8] = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_out", {sdram_adv, sdram_rwn, sdram_i_addr, sdram_data_in}, 0);
    rst = 0;
    @(negedge clk);
    rreg(REG_STATUS, 0, v);  chk("rst_status", v, 0);
    rreg(REG_ADR_LOW, 0, v); chk("rst_adr", v, 0);
    rreg(REG_CTRL, 0, v);    chk("unmapped_rd", v, 0);
    sdram_init_done = 1;

    wreg(REG_ADR_HIGH, 16'h0001); m_hi(16'h0001);
    wreg(REG_ADR_LOW, 16'h0001);  m_lo(16'h0001);
    wreg(REG_DATA, 16'h00A0);     m_wr(16'h00A0, 0);
    chk("adv_early", sdram_adv, 0);
    wreg(REG_DATA, 16'h00A1);     m_wr(16'h00A1, 0);
    chk("adv_lat2", sdram_adv, 1);
    wreg(REG_DATA, 16'h00A2);     m_wr(16'h00A2, 0);
    wait_idle("t1");
    verify("t1");

    hold_busy = 1;
    for (int i = 0; i < 9; i++) begin
      d = 16'($urandom);
      wreg(REG_DATA, d);
      m_wr(d, i == 8);
    end
    rreg(REG_STATUS, 0, v); chk("t2_full", v, exp_st(8, 1));
    hold_busy = 0;
    wait_idle("t2");
    verify("t2");
    wreg(REG_CTRL, 16'h0002); m_ctrl(16'h0002);
    rreg(REG_STATUS, 0, v); chk("t2_clr", v, exp_st(0, 0));
    wreg(REG_CTRL, 16'h0001); m_ctrl(16'h0001);

    wreg(REG_ADR_HIGH, 16'h0000); m_hi(16'h0000);
    wreg(REG_ADR_LOW, 16'h0010);  m_lo(16'h0010);
    wait_idle("t3a");
    verify("t3a");
    rreg(REG_DATA, 1, v); chk("t3_rd", v, 16'h1234); m_rd();
    wait_idle("t3b");
    verify("t3b");

    wreg(REG_CTRL, 16'h0000); m_ctrl(16'h0000);
    rreg(REG_DATA, 1, v); chk("t4_rd1", v, m_pfd); m_rd();
    rreg(REG_DATA, 1, v); chk("t4_rd2", v, m_pfd); m_rd();
    wait_idle("t4");
    verify("t4");
    wreg(REG_CTRL, 16'h0003); m_ctrl(16'h0003);

    wreg(REG_ADR_LOW, 16'h0081); m_lo(16'h0081);
    hold_busy = 1;
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      wreg(REG_DATA, d); m_wr(d, 0);
    end
    wreg(REG_ADR_LOW, 16'h0080); m_lo(16'h0080);
    repeat (4) @(negedge clk);
    hold_busy = 0;
    wait_idle("t5");
    verify("t5");

    wreg(REG_ADR_HIGH, 16'h0FFF); m_hi(16'h0FFF);
    wreg(REG_ADR_LOW, 16'hFFFF);  m_lo(16'hFFFF);
    d = 16'($urandom);
    wreg(REG_DATA, d); m_wr(d, 0);
    wait_idle("t6");
    verify("t6");

    wreg(REG_ADR_LOW, 16'h000B); m_lo(16'h000B);
    fixed_lat = 10;
    d = 16'($urandom) | 16'h1;
    wreg(REG_DATA, d);
    exp_q.push_back({1'b1, 27'd5, d});
    n0 = got_q.size();
    for (int i = 0; i < 50 && got_q.size() == n0; i++) @(negedge clk);
    chk("t7_adv_seen", got_q.size(), n0 + 1);
    @(negedge clk);
    chk("t7_pre_rst", {sdram_rwn, sdram_data_in}, {1'b1, d});
    rst = 1;
    @(negedge clk);
    chk("t7_rst_out", {sdram_adv, sdram_rwn, sdram_i_addr, sdram_data_in}, 0);
    rst = 0;
    m_reset();
    fixed_lat = 0;
    @(negedge clk);
    verify("t7");

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
            d = 16'($urandom);
            wreg(REG_DATA, d); m_wr(d, 0);
          end
        end
        1: begin
          logic [26:0] a;
          if ($urandom_range(0, 3) == 0) a = 27'($urandom);
          else a = 27'($urandom_range(0, 63));
          wreg(REG_ADR_HIGH, 16'(a[26:15])); m_hi(16'(a[26:15]));
          d = {a[14:0], 1'($urandom_range(0, 1))};
          wreg(REG_ADR_LOW, d); m_lo(d);
        end
        2: begin
          rreg(REG_DATA, 1, v); chk("rnd_rd", v, m_pfd); m_rd();
        end
        default: begin
          d = {14'h0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0)};
          wreg(REG_CTRL, d); m_ctrl(d);
        end
      endcase
      wait_idle("rnd");
      verify("rnd");
    end

    chk("protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
